// File: rtl/demux12_buf.sv
// demux12_buf: 1-to-2 demultiplexer that steers each accepted input word
// into one of two independent output FIFOs, selected by S.
// Optional feature: define DEMUX_CNT_EN to add the 16-bit delivered-word
// counters cnt1/cnt2 (absent in the default build).
//
// Handshake: every channel (D, Y1, Y2) transfers a word on a rising clk edge
// where valid=1 and ready=1. A producer holds valid/data until the transfer
// occurs. D_ready depends only on S and FIFO occupancy, never on Y1/Y2_ready.
// Yn_valid and Yn hold steady while Yn_valid=1 and Yn_ready=0.
module demux12_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic             D_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             Y1_valid,
    input  logic             Y1_ready,
    output logic [WIDTH-1:0] Y2,
    output logic             Y2_valid,
    input  logic             Y2_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage is deliberately left out of reset; occupancy gates visibility.
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];

    logic [AW-1:0] wr_ptr1, rd_ptr1, wr_ptr2, rd_ptr2;
    logic [CW-1:0] count1, count2;

    logic full1, full2;
    logic push1, push2, pop1, pop2;

    // Status, ready and transfer qualifiers.
    always_comb begin
        full1    = (count1 == FULL_CNT);
        full2    = (count2 == FULL_CNT);
        // A full FIFO refuses a word even if it is being drained this cycle.
        D_ready  = S ? !full2 : !full1;
        Y1_valid = (count1 != '0);
        Y2_valid = (count2 != '0);
        Y1       = Y1_valid ? mem1[rd_ptr1] : '0;
        Y2       = Y2_valid ? mem2[rd_ptr2] : '0;
        push1    = D_valid && D_ready && !S;
        push2    = D_valid && D_ready && S;
        pop1     = Y1_valid && Y1_ready;
        pop2     = Y2_valid && Y2_ready;
    end

    // Write accepted words into the selected FIFO's storage.
    always_ff @(posedge clk) begin
        if (push1) mem1[wr_ptr1] <= D;
        if (push2) mem2[wr_ptr2] <= D;
    end

    // FIFO1 pointers and occupancy; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            count1  <= '0;
        end else begin
            if (push1) wr_ptr1 <= AW'(wr_ptr1 + AW'(1));
            if (pop1)  rd_ptr1 <= AW'(rd_ptr1 + AW'(1));
            case ({push1, pop1})
                2'b10:   count1 <= count1 + CW'(1);
                2'b01:   count1 <= count1 - CW'(1);
                default: count1 <= count1;
            endcase
        end
    end

    // FIFO2 pointers and occupancy; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr2 <= '0;
            rd_ptr2 <= '0;
            count2  <= '0;
        end else begin
            if (push2) wr_ptr2 <= AW'(wr_ptr2 + AW'(1));
            if (pop2)  rd_ptr2 <= AW'(rd_ptr2 + AW'(1));
            case ({push2, pop2})
                2'b10:   count2 <= count2 + CW'(1);
                2'b01:   count2 <= count2 - CW'(1);
                default: count2 <= count2;
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    // Delivered-word counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (pop1) cnt1 <= cnt1 + 16'd1;
            if (pop2) cnt2 <= cnt2 + 16'd1;
        end
    end
`endif

endmodule

// File: doc/demux12_buf.md
DEMUX12_BUF -- requirements
Module: demux12_buf

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and both outputs.
REQ-002 Parameter: DEPTH, 2, entries per output FIFO; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: S  input  1  destination select; 0 routes to Y1, 1 routes to Y2; sampled only when D_valid=1.
REQ-006 Port: D  input  WIDTH  input data word.
REQ-007 Port: D_valid  input  1  producer offers D.
REQ-008 Port: D_ready  output  1  block accepts D this cycle.
REQ-009 Port: Y1 / Y2  output  WIDTH  head entry of FIFO 1 / FIFO 2.
REQ-010 Port: Y1_valid / Y2_valid  output  1  head entry of FIFO 1 / FIFO 2 present.
REQ-011 Port: Y1_ready / Y2_ready  input  1  consumer 1 / consumer 2 takes head.
REQ-012 Port (DEMUX_CNT_EN only): cnt1 / cnt2  output  16  words delivered on Y1 / Y2.

Function
REQ-013 The block SHALL hold two independent FIFOs, FIFO1 and FIFO2, each DEPTH x WIDTH, with read/write pointers and an occupancy count of log2(DEPTH)+1 bits.
REQ-014 D_ready SHALL be combinational: S=0 -> (FIFO1 not full); S=1 -> (FIFO2 not full); it SHALL NOT depend on Y1_ready or Y2_ready.
REQ-015 A push SHALL occur on a cycle with D_valid=1 and D_ready=1; D is written to FIFO[S+1] at its write pointer, which advances modulo DEPTH.
REQ-016 Yn_valid SHALL be 1 exactly when FIFOn occupancy is nonzero; Yn SHALL equal the entry at FIFOn read pointer, or 0 when empty.
REQ-017 A pop on FIFOn SHALL occur on a cycle with Yn_valid=1 and Yn_ready=1; the read pointer advances modulo DEPTH.
REQ-018 Latency: a word pushed in cycle N SHALL appear on Yn with Yn_valid=1 in cycle N+1; no same-cycle bypass.
REQ-019 Simultaneous push and pop on the same FIFO SHALL leave occupancy unchanged and move both pointers.
REQ-020 When a FIFO is full, D_ready SHALL be 0 for that destination even if its consumer pops in the same cycle.
REQ-021 A full FIFO SHALL NOT block pushes to the other FIFO; S may change every cycle.
REQ-022 Word order within each output SHALL match acceptance order; no ordering holds between outputs.
REQ-023 Yn and Yn_valid SHALL stay stable while Yn_valid=1 and Yn_ready=0.
REQ-024 With D_valid=0 the block SHALL ignore S and D.

Reset
REQ-025 On rising clk with rst=1: all pointers and occupancies SHALL be 0, Y1_valid=Y2_valid=0, Y1=Y2=0, and D_ready=1 from the next cycle.
REQ-026 Reset SHALL take priority over a same-cycle push or pop; in-flight entries are discarded and storage contents need not clear.

Configuration
REQ-027 With DEMUX_CNT_EN defined: cnt1/cnt2 SHALL exist, reset to 0, increment by 1 on each pop of FIFO1/FIFO2, and wrap 16'hFFFF -> 16'h0000.
REQ-028 With DEMUX_CNT_EN undefined: cnt1/cnt2 ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then push D=32'hA5A5_0001 with S=0 while Y1_ready=1 -> next cycle Y1=32'hA5A5_0001, Y1_valid=1; Y2_valid stays 0.
REQ-030 DEPTH=2, Y2_ready=0, three pushes with S=1 (32'h1, 32'h2, 32'h3) -> D_ready=0 on the third offer; later raising Y2_ready yields 32'h1 then 32'h2, and 32'h3 is accepted only after the first pop.
REQ-031 FIFO2 full with S alternating 1,0 -> S=1 offers stall and S=0 offers of 32'hCAFE_0000 are accepted and reach Y1 the next cycle.
REQ-032 FIFO1 at 1 entry, push and pop together for 10 cycles -> occupancy stays 1 and Y1 carries the words in order.
REQ-033 Two words queued in FIFO1, rst=1 for one cycle together with D_valid=1 -> Y1_valid=0 and Y1=0 afterwards; no word appears on either output.
REQ-034 DEMUX_CNT_EN defined, cnt1 preloaded by 65535 pops, then one more pop -> cnt1=16'h0000.
